id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register for the five-stage RV32I core. It captures the decoded control bundle from the instruction decoder, along with register-file read data, the extended immediate, PC values and register indices, and presents them to the execute stage one cycle later. It also detects load-use hazards: it stalls fetch/decode and inserts a bubble into execute. It applies execute-stage flushes from branch/jump resolution.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 32, width of the bubble counter
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `RegWriteD, MemWriteD, PCBranchD, SrcBSelD, MemtoRegD`  in  1 each  decoder control bits
- `SrcASelD`  in  2  00 PC, 01 zero (LUI), 11 rs1
- `ALUopD`  in  4  ALU operation
- `strCtrlD`  in  3  load/store/branch funct3
- `RD1D, RD2D, ImmExtD, PCD, PCPlus4D`  in  XLEN each  decode-stage data
- `Rs1D, Rs2D, RdD`  in  5 each  register indices
- `FlushE`  in  1  branch/jump taken in EX; kill the instruction entering EX
- `StallE`  in  1  downstream hold; freeze EX contents
- The same control, data and index set with suffix E (`RegWriteE` … `RdE`)  out  same widths  registered copies
- `ValidE`  out  1  EX holds a real instruction
- `StallD`  out  1  hold PC and the IF/ID register this cycle
- `BubbleCnt`  out  CNT_W  load-use bubble count

## Operation
- **Operand-use qualifiers (combinational):**
  - use_rs1 = (SrcASelD == 2'b11).
  - use_rs2 = !SrcBSelD | MemWriteD.
- **Load-use hazard:** load_use = ValidE & MemtoRegE & (RdE != 0) & ((use_rs1 & RdE == Rs1D) | (use_rs2 & RdE == Rs2D)).
- **StallD** = load_use | StallE.
- **Per-cycle register update, priority high→low:**
  1. `rst`: every E output = 0, ValidE = 0.
  2. FlushE: load a bubble. A flush wins over StallE and load_use.
  3. StallE: hold all E registers unchanged.
  4. load_use: load a bubble.
  5. Otherwise: copy all D inputs to E outputs and set ValidE = 1.
- **Bubble contents:**
  - ValidE = 0.
  - RegWriteE, MemWriteE, PCBranchE, MemtoRegE = 0.
  - All other fields = 0, for deterministic waveforms.
- **Control bits vs ValidE:** while ValidE = 0, the control bits are always 0, so downstream logic may gate on either.
- **x0 destination:** RdE = 0 never raises load_use, even for a load to x0.

## Timing
- Latency: exactly one cycle from D inputs to E outputs.
- StallD is combinational from the current E state and the current D inputs. It is valid in the same cycle and carries no registered delay.
- A load followed immediately by a dependent instruction produces:
  - exactly one bubble cycle;
  - StallD high for exactly one cycle;
  - the dependent instruction entering EX on the next cycle, when the load has moved to MEM and is no longer in EX.
- A load followed by an independent instruction produces no stall.
- Simultaneous FlushE and load_use: one bubble cycle. StallD is still high that cycle; upstream discards the held instruction through its own flush.
- StallE held for N cycles: E outputs are constant for N cycles and StallD is high for those N cycles.
- `rst` asserted mid-operation: outputs are zero on the next edge, regardless of FlushE/StallE. StallD is 0 one cycle after reset, because ValidE = 0.

## Configuration
- Macro: `ID_EX_BUBBLE_CNT_EN`.
- **Defined:**
  - BubbleCnt resets to 0.
  - It increments by 1 on every edge where a bubble is loaded because of load_use with FlushE = 0 and StallE = 0.
  - It wraps modulo 2^CNT_W.
  - Flush bubbles are not counted.
- **Undefined:** BubbleCnt is tied to 0 and no counter register is synthesized. All other behaviour is identical.

## Test plan
- **Reset then pass-through:**
  - Stimulus: hold `rst` 2 cycles; all E outputs read 0 and ValidE = 0. Then present an ADD with RdD = 5, RD1D = 0x10, RD2D = 0x20, ALUopD = 0000.
  - Required: next cycle RdE = 5, RD1E = 0x10, RD2E = 0x20, ValidE = 1, StallD = 0.
- **Load-use:**
  - Stimulus: LW with RdD = 3 (MemtoRegD = 1), then ADD with Rs1D = 3 held at the D inputs.
  - Required: StallD = 1 for one cycle; one bubble (ValidE = 0, RegWriteE = 0); then the ADD appears in EX. With the macro defined, BubbleCnt = 1.
- **No false hazard:**
  - Stimulus: LW to x0, then ADD with Rs1D = 0; separately, LW to x3, then LUI (SrcASelD = 01, SrcBSelD = 1) targeting x7.
  - Required: StallD = 0 in both cases.
- **Flush priority:**
  - Stimulus: FlushE = 1 together with StallE = 1 and a valid store at D.
  - Required: next cycle ValidE = 0 and MemWriteE = 0. BubbleCnt is unchanged.
- **Stall hold:**
  - Stimulus: StallE = 1 for 3 cycles with changing D inputs.
  - Required: E outputs are constant across all 3 cycles and StallD = 1 throughout.
- **Counter wrap (CNT_W = 4):**
  - Stimulus: force 17 load-use bubbles.
  - Required: BubbleCnt = 1 with the macro defined; BubbleCnt = 0 with it undefined.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: carries the decoded bundle into EX,
// detects load-use hazards and applies EX flushes. Optional bubble counter: ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             PCBranchD,
  input  logic             SrcBSelD,
  input  logic             MemtoRegD,
  input  logic [1:0]       SrcASelD,
  input  logic [3:0]       ALUopD,
  input  logic [2:0]       strCtrlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             FlushE,
  input  logic             StallE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             PCBranchE,
  output logic             SrcBSelE,
  output logic             MemtoRegE,
  output logic [1:0]       SrcASelE,
  output logic [3:0]       ALUopE,
  output logic [2:0]       strCtrlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic             StallD,
  output logic [CNT_W-1:0] BubbleCnt
);

  typedef struct packed {
    logic            regWrite;
    logic            memWrite;
    logic            pcBranch;
    logic            srcBSel;
    logic            memtoReg;
    logic [1:0]      srcASel;
    logic [3:0]      aluOp;
    logic [2:0]      strCtrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] immExt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } stageBundle_t;

  stageBundle_t dBundle_s;
  stageBundle_t eNext_s;
  stageBundle_t eBundle_r;
  logic         validNext_s;
  logic         validE_r;
  logic         useRs1_s;
  logic         useRs2_s;
  logic         loadUse_s;

  assign dBundle_s = {RegWriteD, MemWriteD, PCBranchD, SrcBSelD, MemtoRegD,
                      SrcASelD, ALUopD, strCtrlD,
                      RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
                      Rs1D, Rs2D, RdD};

  // Load-use detection against the instruction currently held in EX; x0 never hazards.
  always_comb begin
    useRs1_s  = (SrcASelD == 2'b11);
    useRs2_s  = ~SrcBSelD | MemWriteD;
    loadUse_s = validE_r & eBundle_r.memtoReg & (eBundle_r.rd != 5'd0) &
                ((useRs1_s & (eBundle_r.rd == Rs1D)) |
                 (useRs2_s & (eBundle_r.rd == Rs2D)));
  end

  assign StallD = loadUse_s | StallE;

  // Next EX contents: flush beats hold, hold beats the load-use bubble.
  always_comb begin
    eNext_s     = eBundle_r;
    validNext_s = validE_r;
    if (FlushE) begin
      eNext_s     = '0;
      validNext_s = 1'b0;
    end else if (StallE) begin
      eNext_s     = eBundle_r;
      validNext_s = validE_r;
    end else if (loadUse_s) begin
      eNext_s     = '0;
      validNext_s = 1'b0;
    end else begin
      eNext_s     = dBundle_s;
      validNext_s = 1'b1;
    end
  end

  // EX register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      eBundle_r <= '0;
      validE_r  <= 1'b0;
    end else begin
      eBundle_r <= eNext_s;
      validE_r  <= validNext_s;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubbleCnt_r;

  // Count only bubbles caused by load-use; flush bubbles and held cycles are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCnt_r <= '0;
    end else if (!FlushE && !StallE && loadUse_s) begin
      bubbleCnt_r <= bubbleCnt_r + CNT_W'(1);
    end else begin
      bubbleCnt_r <= bubbleCnt_r;
    end
  end

  assign BubbleCnt = bubbleCnt_r;
`else
  assign BubbleCnt = '0;
`endif

  assign RegWriteE = eBundle_r.regWrite;
  assign MemWriteE = eBundle_r.memWrite;
  assign PCBranchE = eBundle_r.pcBranch;
  assign SrcBSelE  = eBundle_r.srcBSel;
  assign MemtoRegE = eBundle_r.memtoReg;
  assign SrcASelE  = eBundle_r.srcASel;
  assign ALUopE    = eBundle_r.aluOp;
  assign strCtrlE  = eBundle_r.strCtrl;
  assign RD1E      = eBundle_r.rd1;
  assign RD2E      = eBundle_r.rd2;
  assign ImmExtE   = eBundle_r.immExt;
  assign PCE       = eBundle_r.pc;
  assign PCPlus4E  = eBundle_r.pcPlus4;
  assign Rs1E      = eBundle_r.rs1;
  assign Rs2E      = eBundle_r.rs2;
  assign RdE       = eBundle_r.rd;
  assign ValidE    = validE_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage, checked against a behavioural model
// of the EX slot (what instruction EX should hold, and how many load-use bubbles occurred).
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic        regWrite;
    logic        memWrite;
    logic        pcBranch;
    logic        srcBSel;
    logic        memtoReg;
    logic [1:0]  srcASel;
    logic [3:0]  aluOp;
    logic [2:0]  strCtrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immExt;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } instr_t;

  logic clk = 1'b0;
  logic rst, FlushE, StallE;
  instr_t dIn;

  logic RegWriteE, MemWriteE, PCBranchE, SrcBSelE, MemtoRegE, ValidE, StallD;
  logic [1:0] SrcASelE;
  logic [3:0] ALUopE;
  logic [2:0] strCtrlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [CNT_W-1:0] BubbleCnt;
  instr_t eObs;

  instr_t mCur;
  logic   mValid = 1'b0;
  int     mCnt = 0;
  bit     mKnown = 1'b0;
  int     compared = 0;
  int     mismatched = 0;
  int     cntSaved;
  instr_t snap;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteD(dIn.regWrite), .MemWriteD(dIn.memWrite), .PCBranchD(dIn.pcBranch),
    .SrcBSelD(dIn.srcBSel), .MemtoRegD(dIn.memtoReg), .SrcASelD(dIn.srcASel),
    .ALUopD(dIn.aluOp), .strCtrlD(dIn.strCtrl),
    .RD1D(dIn.rd1), .RD2D(dIn.rd2), .ImmExtD(dIn.immExt), .PCD(dIn.pc), .PCPlus4D(dIn.pcPlus4),
    .Rs1D(dIn.rs1), .Rs2D(dIn.rs2), .RdD(dIn.rd),
    .FlushE(FlushE), .StallE(StallE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCBranchE(PCBranchE),
    .SrcBSelE(SrcBSelE), .MemtoRegE(MemtoRegE), .SrcASelE(SrcASelE),
    .ALUopE(ALUopE), .strCtrlE(strCtrlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ValidE(ValidE), .StallD(StallD), .BubbleCnt(BubbleCnt)
  );

  assign eObs = {RegWriteE, MemWriteE, PCBranchE, SrcBSelE, MemtoRegE, SrcASelE, ALUopE, strCtrlE,
                 RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};

  initial forever #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Does the instruction at D read a register that the load in EX is still producing?
  function automatic bit modelHazard();
    bit readsRs1, readsRs2;
    readsRs1 = (dIn.srcASel == 2'b11);
    readsRs2 = !dIn.srcBSel || dIn.memWrite;
    return mValid && mCur.memtoReg && (mCur.rd != 5'd0) &&
           ((readsRs1 && mCur.rd == dIn.rs1) || (readsRs2 && mCur.rd == dIn.rs2));
  endfunction

  function automatic int expCnt();
`ifdef ID_EX_BUBBLE_CNT_EN
    return mCnt;
`else
    return 0;
`endif
  endfunction

  // One clock: check StallD before the edge, advance the model, check EX after it.
  task automatic cycle();
    bit hz;
    #1;
    if (mKnown) checkVal("StallD", StallD, modelHazard() || StallE);
    hz = modelHazard();
    @(posedge clk);
    if (rst) begin
      mCur = '0; mValid = 1'b0; mCnt = 0; mKnown = 1'b1;
    end else if (FlushE) begin
      mCur = '0; mValid = 1'b0;
    end else if (StallE) begin
      mCur = mCur;
    end else if (hz) begin
      mCur = '0; mValid = 1'b0; mCnt = (mCnt + 1) % (1 << CNT_W);
    end else begin
      mCur = dIn; mValid = 1'b1;
    end
    #1;
    checkVal("Ebundle", eObs, mCur);
    checkVal("ValidE", ValidE, mValid);
    checkVal("BubbleCnt", BubbleCnt, expCnt());
    @(negedge clk);
  endtask

  function automatic instr_t mkBase();
    instr_t i;
    i = '0;
    i.pc = $urandom & 32'hFFFF_FFFC;
    i.pcPlus4 = i.pc + 32'd4;
    i.immExt = $urandom;
    return i;
  endfunction

  function automatic instr_t mkAdd(input logic [4:0] rd, rs1, rs2, input logic [31:0] a, b);
    instr_t i;
    i = mkBase();
    i.regWrite = 1'b1; i.srcASel = 2'b11; i.srcBSel = 1'b0; i.aluOp = 4'b0000;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.rd1 = a; i.rd2 = b;
    return i;
  endfunction

  function automatic instr_t mkLoad(input logic [4:0] rd, rs1);
    instr_t i;
    i = mkBase();
    i.regWrite = 1'b1; i.memtoReg = 1'b1; i.srcASel = 2'b11; i.srcBSel = 1'b1; i.strCtrl = 3'b010;
    i.rd = rd; i.rs1 = rs1; i.rs2 = 5'd3; i.rd1 = $urandom;
    return i;
  endfunction

  function automatic instr_t mkStore(input logic [4:0] rs1, rs2);
    instr_t i;
    i = mkBase();
    i.memWrite = 1'b1; i.srcASel = 2'b11; i.srcBSel = 1'b1; i.strCtrl = 3'b010;
    i.rs1 = rs1; i.rs2 = rs2; i.rd1 = $urandom; i.rd2 = $urandom;
    return i;
  endfunction

  function automatic instr_t mkLui(input logic [4:0] rd);
    instr_t i;
    i = mkBase();
    i.regWrite = 1'b1; i.srcASel = 2'b01; i.srcBSel = 1'b1;
    i.rd = rd; i.rs1 = 5'd3; i.rs2 = 5'd3;
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    i.rs1 = 5'($urandom_range(0, 3));
    i.rs2 = 5'($urandom_range(0, 3));
    i.rd  = 5'($urandom_range(0, 3));
    i.memtoReg = ($urandom_range(0, 2) == 0);
    return i;
  endfunction

  initial begin
    rst = 1'b1; FlushE = 1'b0; StallE = 1'b0; dIn = randInstr();
    @(negedge clk);
    cycle();
    dIn = randInstr();
    cycle();
    checkVal("rstValidE", ValidE, 1'b0);
    checkVal("rstEzero", eObs, 189'd0);

    // Pass-through of an ADD
    rst = 1'b0;
    dIn = mkAdd(5'd5, 5'd1, 5'd2, 32'h10, 32'h20);
    cycle();
    checkVal("addRdE", RdE, 5'd5);
    checkVal("addRD1E", RD1E, 32'h10);
    checkVal("addRD2E", RD2E, 32'h20);
    checkVal("addValidE", ValidE, 1'b1);

    // Load followed by dependent ADD: one bubble, one stall cycle
    dIn = mkLoad(5'd3, 5'd1);
    cycle();
    dIn = mkAdd(5'd4, 5'd3, 5'd2, 32'h1, 32'h2);
    #1 checkVal("luStallD", StallD, 1'b1);
    cycle();
    checkVal("luBubbleValid", ValidE, 1'b0);
    checkVal("luBubbleRegWr", RegWriteE, 1'b0);
    #1 checkVal("luStallDrop", StallD, 1'b0);
    cycle();
    checkVal("luAddRdE", RdE, 5'd4);
    checkVal("luAddValid", ValidE, 1'b1);
`ifdef ID_EX_BUBBLE_CNT_EN
    checkVal("luCnt", BubbleCnt, 4'd1);
`else
    checkVal("luCnt", BubbleCnt, 4'd0);
`endif

    // No false hazards: load to x0, and LUI after a load to x3
    dIn = mkLoad(5'd0, 5'd1);
    cycle();
    dIn = mkAdd(5'd6, 5'd0, 5'd0, 32'h5, 32'h6);
    #1 checkVal("x0NoStall", StallD, 1'b0);
    cycle();
    dIn = mkLoad(5'd3, 5'd1);
    cycle();
    dIn = mkLui(5'd7);
    #1 checkVal("luiNoStall", StallD, 1'b0);
    cycle();

    // Flush wins over stall and over a pending load-use
    dIn = mkLoad(5'd3, 5'd1);
    cycle();
    dIn = mkStore(5'd1, 5'd3);
    FlushE = 1'b1; StallE = 1'b1;
    cntSaved = expCnt();
    #1 checkVal("flushStallD", StallD, 1'b1);
    cycle();
    checkVal("flushValidE", ValidE, 1'b0);
    checkVal("flushMemWrE", MemWriteE, 1'b0);
    checkVal("flushCnt", BubbleCnt, cntSaved);
    FlushE = 1'b0; StallE = 1'b0;

    // StallE holds EX for three cycles
    dIn = mkAdd(5'd9, 5'd1, 5'd2, 32'hABCD, 32'h1234);
    cycle();
    snap = mCur;
    StallE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dIn = randInstr();
      #1 checkVal("holdStallD", StallD, 1'b1);
      cycle();
      checkVal("holdE", eObs, snap);
    end
    StallE = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      StallE = ($urandom_range(0, 5) == 0);
      dIn    = randInstr();
      cycle();
    end

    // Counter wrap: 17 load-use bubbles with a 4-bit counter
    rst = 1'b1; FlushE = 1'b0; StallE = 1'b0;
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 17; n++) begin
      dIn = mkLoad(5'd3, 5'd1);
      cycle();
      dIn = mkAdd(5'd4, 5'd3, 5'd2, 32'h7, 32'h8);
      cycle();
      cycle();
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    checkVal("wrapCnt", BubbleCnt, 4'd1);
`else
    checkVal("wrapCnt", BubbleCnt, 4'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
